// File: rtl/stack_sequencer.sv
// Stack microsequencer: pushes a register pair to memory or pops one back,
// one byte per bus transfer. SP is adjusted through the register array.
// Pair codes (i8080.vh): BC=0 DE=1 HL=2 SP=3 WZ=4 PC=5; nib_sel 1 = high byte.
module stack_sequencer #(
    parameter int XLEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [2:0]        rp,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        reg_sel,
    output logic [XLEN-1:0]   reg_wdata,
    output logic              reg_wenable,
    output logic              reg_inc,
    output logic              reg_dec,
    input  logic [2*XLEN-1:0] reg_rpdata,
    input  logic [XLEN-1:0]   reg_rdata,
    output logic [2*XLEN-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready
);

    localparam logic [2:0] RP_BC = 3'd0;
    localparam logic [2:0] RP_DE = 3'd1;
    localparam logic [2:0] RP_HL = 3'd2;
    localparam logic [2:0] RP_SP = 3'd3;
    localparam logic [2:0] RP_WZ = 3'd4;
    localparam logic [2:0] RP_PC = 3'd5;

    localparam logic NIB_LO = 1'b0;
    localparam logic NIB_HI = 1'b1;

    localparam logic [4:0] S_IDLE    = 5'd0;
    localparam logic [4:0] S_ILL     = 5'd1;
    localparam logic [4:0] S_DONE    = 5'd2;
    localparam logic [4:0] S_P_DEC1  = 5'd3;
    localparam logic [4:0] S_P_ADDR1 = 5'd4;
    localparam logic [4:0] S_P_DATA1 = 5'd5;
    localparam logic [4:0] S_P_WR1   = 5'd6;
    localparam logic [4:0] S_P_DEC2  = 5'd7;
    localparam logic [4:0] S_P_ADDR2 = 5'd8;
    localparam logic [4:0] S_P_DATA2 = 5'd9;
    localparam logic [4:0] S_P_WR2   = 5'd10;
    localparam logic [4:0] S_O_ADDR1 = 5'd11;
    localparam logic [4:0] S_O_RD1   = 5'd12;
    localparam logic [4:0] S_O_WB1   = 5'd13;
    localparam logic [4:0] S_O_INC1  = 5'd14;
    localparam logic [4:0] S_O_ADDR2 = 5'd15;
    localparam logic [4:0] S_O_RD2   = 5'd16;
    localparam logic [4:0] S_O_WB2   = 5'd17;
    localparam logic [4:0] S_O_INC2  = 5'd18;

    logic [4:0]        r_state;
    logic [4:0]        w_next;
    logic [2:0]        r_rp;
    logic [XLEN-1:0]   r_capture;
    logic [2*XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              w_legal;

    // SP itself cannot be pushed or popped; only the five real pairs are accepted.
    assign w_legal = (rp == RP_BC) || (rp == RP_DE) || (rp == RP_HL) ||
                     (rp == RP_WZ) || (rp == RP_PC);

    assign reg_wdata = r_capture;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Next-state sequencing; bus states hold until the memory signals ready.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!w_legal)
                        w_next = S_ILL;
                    else if (op)
                        w_next = S_O_ADDR1;
                    else
                        w_next = S_P_DEC1;
                end
            end
            S_ILL:     w_next = S_IDLE;
            S_P_DEC1:  w_next = S_P_ADDR1;
            S_P_ADDR1: w_next = S_P_DATA1;
            S_P_DATA1: w_next = S_P_WR1;
            S_P_WR1:   w_next = mem_ready ? S_P_DEC2 : S_P_WR1;
            S_P_DEC2:  w_next = S_P_ADDR2;
            S_P_ADDR2: w_next = S_P_DATA2;
            S_P_DATA2: w_next = S_P_WR2;
            S_P_WR2:   w_next = mem_ready ? S_DONE : S_P_WR2;
            S_O_ADDR1: w_next = S_O_RD1;
            S_O_RD1:   w_next = mem_ready ? S_O_WB1 : S_O_RD1;
            S_O_WB1:   w_next = S_O_INC1;
            S_O_INC1:  w_next = S_O_ADDR2;
            S_O_ADDR2: w_next = S_O_RD2;
            S_O_RD2:   w_next = mem_ready ? S_O_WB2 : S_O_RD2;
            S_O_WB2:   w_next = S_O_INC2;
            S_O_INC2:  w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State, latched pair, read capture and registered bus address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rp        <= 3'd0;
            r_capture   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start && w_legal)
                r_rp <= rp;
            if ((r_state == S_O_RD1 || r_state == S_O_RD2) && mem_ready)
                r_capture <= mem_rdata;
            if (r_state == S_P_ADDR1 || r_state == S_P_ADDR2 ||
                r_state == S_O_ADDR1 || r_state == S_O_ADDR2)
                r_mem_addr <= reg_rpdata;
            if (r_state == S_P_DATA1 || r_state == S_P_DATA2)
                r_mem_wdata <= reg_rdata;
        end
    end

    // Moore decode of register-array commands and bus strobes.
    always_comb begin
        busy        = (r_state != S_IDLE) && (r_state != S_ILL);
        done        = 1'b0;
        illegal     = 1'b0;
        reg_sel     = 4'd0;
        reg_wenable = 1'b0;
        reg_inc     = 1'b0;
        reg_dec     = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        case (r_state)
            S_ILL:  illegal = 1'b1;
            S_DONE: done = 1'b1;
            S_P_DEC1, S_P_DEC2: begin
                reg_sel = {RP_SP, NIB_LO};
                reg_dec = 1'b1;
            end
            S_P_ADDR1, S_P_ADDR2, S_O_ADDR1, S_O_ADDR2: reg_sel = {RP_SP, NIB_LO};
            S_P_DATA1: reg_sel = {r_rp, NIB_HI};
            S_P_DATA2: reg_sel = {r_rp, NIB_LO};
            S_P_WR1, S_P_WR2: mem_wr = 1'b1;
            S_O_RD1, S_O_RD2: mem_rd = 1'b1;
            S_O_WB1: begin
                reg_sel     = {r_rp, NIB_LO};
                reg_wenable = 1'b1;
            end
            S_O_WB2: begin
                reg_sel     = {r_rp, NIB_HI};
                reg_wenable = 1'b1;
            end
            S_O_INC1, S_O_INC2: begin
                reg_sel = {RP_SP, NIB_LO};
                reg_inc = 1'b1;
            end
            default: begin
                reg_sel = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: register array and memory responders, a
// transaction-level model of timing and bus traffic, and directed plus
// random PUSH/POP sequences.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, op;
    logic [2:0]  rp;
    logic        busy, done, illegal, reg_wenable, reg_inc, reg_dec;
    logic [3:0]  reg_sel;
    logic [7:0]  reg_wdata, reg_rdata, mem_wdata, mem_rdata;
    logic [15:0] reg_rpdata, mem_addr;
    logic        mem_rd, mem_wr, mem_ready;

    bit [15:0]   regs [0:7];
    bit [7:0]    mem  [0:65535];
    bit          pl_en;
    logic [2:0]  pl_idx;
    logic [15:0] pl_val;

    int          waits [0:1];
    logic [15:0] exp_addr [0:1];
    logic [7:0]  exp_data [0:1];
    bit          exp_wr;
    int          xfer_idx, wait_cnt;
    int          m_rem;
    bit          m_ill;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    stack_sequencer #(.XLEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rp(rp),
        .busy(busy), .done(done), .illegal(illegal),
        .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_wenable(reg_wenable),
        .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_rpdata(reg_rpdata), .reg_rdata(reg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit legal_rp(input logic [2:0] r);
        return (r == 3'd0) || (r == 3'd1) || (r == 3'd2) || (r == 3'd4) || (r == 3'd5);
    endfunction

    // Register array responder: byte writes, pair inc/dec, and bench preloads.
    assign reg_rpdata = regs[reg_sel[3:1]];
    assign reg_rdata  = reg_sel[0] ? regs[reg_sel[3:1]][15:8] : regs[reg_sel[3:1]][7:0];

    always @(posedge clk) begin
        if (pl_en) regs[pl_idx] <= pl_val;
        else begin
            if (reg_wenable) begin
                if (reg_sel[0]) regs[reg_sel[3:1]][15:8] <= reg_wdata;
                else            regs[reg_sel[3:1]][7:0]  <= reg_wdata;
            end
            if (reg_inc) regs[reg_sel[3:1]] <= regs[reg_sel[3:1]] + 16'd1;
            if (reg_dec) regs[reg_sel[3:1]] <= regs[reg_sel[3:1]] - 16'd1;
        end
    end

    // Memory responder: ready after the configured number of wait cycles per transfer.
    assign mem_rdata = mem[mem_addr];
    assign mem_ready = (wait_cnt >= ((xfer_idx == 0) ? waits[0] : waits[1]));

    always @(posedge clk) begin
        if (!busy) begin
            xfer_idx <= 0;
            wait_cnt <= 0;
        end else if (mem_rd || mem_wr) begin
            if (mem_ready) begin
                if (mem_wr) mem[mem_addr] <= mem_wdata;
                xfer_idx <= xfer_idx + 1;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // Timing model: an accepted op occupies 9 cycles plus its wait cycles, done on the last.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem <= 0;
            m_ill <= 1'b0;
        end else if (m_rem > 0) m_rem <= m_rem - 1;
        else if (m_ill) m_ill <= 1'b0;
        else if (start) begin
            if (legal_rp(rp)) m_rem <= 9 + waits[0] + waits[1];
            else              m_ill <= 1'b1;
        end
    end

    // Per-cycle comparison of handshake outputs and bus traffic against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("done", 32'(done), 32'(m_rem == 1));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        if (m_rem == 0)
            chk("idle_outputs", 32'({reg_sel, reg_wenable, reg_inc, reg_dec, mem_rd, mem_wr}), 32'd0);
        else if (mem_rd || mem_wr) begin
            if (xfer_idx < 2) begin
                chk("strobe_kind", 32'({mem_rd, mem_wr}), exp_wr ? 32'd1 : 32'd2);
                chk("bus_addr", 32'(mem_addr), 32'((xfer_idx == 0) ? exp_addr[0] : exp_addr[1]));
                if (exp_wr)
                    chk("bus_wdata", 32'(mem_wdata), 32'((xfer_idx == 0) ? exp_data[0] : exp_data[1]));
            end else begin
                chk("extra_strobe", 32'({mem_rd, mem_wr}), 32'd0);
            end
        end
    end

    task automatic load(input logic [2:0] idx, input logic [15:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_op(input bit o, input logic [2:0] r, input int w0, input int w1, input bit poke,
                          output int lat, output int nbusy, output int nwr, output int nwr_first);
        logic [15:0] s, v, exp_sp, exp_val;
        bit seen;
        @(negedge clk);
        s = regs[3];
        v = regs[r];
        if (!o) begin
            exp_addr[0] = s - 16'd1; exp_data[0] = v[15:8];
            exp_addr[1] = s - 16'd2; exp_data[1] = v[7:0];
            exp_wr = 1'b1; exp_sp = s - 16'd2; exp_val = v;
        end else begin
            exp_addr[0] = s; exp_addr[1] = s + 16'd1;
            exp_data[0] = 8'd0; exp_data[1] = 8'd0;
            exp_wr = 1'b0; exp_sp = s + 16'd2;
            exp_val = {mem[s + 16'd1], mem[s]};
        end
        waits[0] = w0; waits[1] = w1;
        op = o; rp = r; start = 1'b1;
        @(posedge clk);
        lat = 0; nbusy = 0; nwr = 0; nwr_first = 0; seen = 1'b0;
        if (!legal_rp(r)) begin
            @(negedge clk);
            start = 1'b0;
            chk("ill_pulse", 32'(illegal), 32'd1);
            chk("ill_busy", 32'(busy), 32'd0);
            chk("ill_sp_unchanged", 32'(regs[3]), 32'(s));
            return;
        end
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 1) begin start = 1'b0; op = ~o; rp = 3'($urandom); end
            if (poke && n == 3) start = 1'b1;
            if (poke && n == 4) start = 1'b0;
            if (busy) nbusy++;
            if (mem_wr) nwr++;
            if (mem_wr && mem_addr == exp_addr[0]) nwr_first++;
            if (done) begin lat = n; seen = 1'b1; break; end
        end
        chk("done_seen", 32'(done), 32'd1);
        if (seen) begin
            chk("sp_after", 32'(regs[3]), 32'(exp_sp));
            if (!o) begin
                chk("mem_hi_byte", 32'(mem[exp_addr[0]]), 32'(exp_data[0]));
                chk("mem_lo_byte", 32'(mem[exp_addr[1]]), 32'(exp_data[1]));
            end else begin
                chk("pair_after_pop", 32'(regs[r]), 32'(exp_val));
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, nb, nw, nwf, w0, w1;
        bit o;
        logic [2:0] r;
        rst_n = 1'b1; start = 1'b0; op = 1'b0; rp = 3'd0;
        pl_en = 1'b0; pl_idx = 3'd0; pl_val = 16'd0;
        waits[0] = 0; waits[1] = 0; exp_wr = 1'b0;
        exp_addr[0] = 16'd0; exp_addr[1] = 16'd0; exp_data[0] = 8'd0; exp_data[1] = 8'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_controls", 32'({done, illegal, reg_sel, reg_wenable, reg_inc, reg_dec, mem_rd, mem_wr}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        rst_n = 1'b1;

        // PUSH BC, zero wait
        load(3'd3, 16'h2400); load(3'd0, 16'h1234);
        run_op(1'b0, 3'd0, 0, 0, 1'b0, lat, nb, nw, nwf);
        chk("t1_latency", lat, 9);
        chk("t1_busy_cycles", nb, 9);
        chk("t1_mem_23ff", 32'(mem[16'h23FF]), 32'h12);
        chk("t1_mem_23fe", 32'(mem[16'h23FE]), 32'h34);
        chk("t1_sp", 32'(regs[3]), 32'h23FE);

        // POP HL back
        load(3'd2, 16'h0000);
        run_op(1'b1, 3'd2, 0, 0, 1'b0, lat, nb, nw, nwf);
        chk("t2_latency", lat, 9);
        chk("t2_hl", 32'(regs[2]), 32'h1234);
        chk("t2_sp", 32'(regs[3]), 32'h2400);
        chk("t2_no_mem_wr", nw, 0);

        // PUSH DE with three wait cycles on the first write
        load(3'd1, 16'h5678);
        run_op(1'b0, 3'd1, 3, 0, 1'b0, lat, nb, nw, nwf);
        chk("t3_latency", lat, 12);
        chk("t3_first_wr_cycles", nwf, 4);
        chk("t3_mem_23ff", 32'(mem[16'h23FF]), 32'h56);
        chk("t3_mem_23fe", 32'(mem[16'h23FE]), 32'h78);

        // PUSH PC across the address wrap
        load(3'd5, 16'hABCD); load(3'd3, 16'h0000);
        run_op(1'b0, 3'd5, 0, 0, 1'b0, lat, nb, nw, nwf);
        chk("t4_mem_ffff", 32'(mem[16'hFFFF]), 32'hAB);
        chk("t4_mem_fffe", 32'(mem[16'hFFFE]), 32'hCD);
        chk("t4_sp", 32'(regs[3]), 32'hFFFE);

        // Illegal start with rp=SP, then a start pulse while busy
        run_op(1'b0, 3'd3, 0, 0, 1'b0, lat, nb, nw, nwf);
        load(3'd3, 16'h1000); load(3'd2, 16'hC0DE);
        run_op(1'b0, 3'd2, 1, 1, 1'b1, lat, nb, nw, nwf);
        chk("t5_latency", lat, 11);
        @(negedge clk);
        chk("t5_no_retrigger", 32'(busy), 32'd0);

        // Asynchronous reset while the first write is stalled
        load(3'd3, 16'h3000); load(3'd0, 16'hBEEF);
        @(negedge clk);
        waits[0] = 30; waits[1] = 0;
        exp_addr[0] = 16'h2FFF; exp_data[0] = 8'hBE;
        exp_addr[1] = 16'h2FFE; exp_data[1] = 8'hEF; exp_wr = 1'b1;
        op = 1'b0; rp = 3'd0; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (mem_wr) break;
        end
        chk("t6_in_wr1", 32'(mem_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy_drop", 32'(busy), 32'd0);
        chk("t6_wr_drop", 32'(mem_wr), 32'd0);
        chk("t6_reg_ctrl_drop", 32'({reg_sel, reg_wenable, reg_inc, reg_dec}), 32'd0);
        chk("t6_addr_clear", 32'(mem_addr), 32'd0);
        @(negedge clk);
        chk("t6_sp_dec_once", 32'(regs[3]), 32'h2FFF);
        rst_n = 1'b1;
        run_op(1'b0, 3'd0, 0, 0, 1'b0, lat, nb, nw, nwf);
        chk("t6_fresh_latency", lat, 9);
        chk("t6_fresh_mem_2ffe", 32'(mem[16'h2FFE]), 32'hBE);
        chk("t6_fresh_mem_2ffd", 32'(mem[16'h2FFD]), 32'hEF);
        chk("t6_fresh_sp", 32'(regs[3]), 32'h2FFD);

        // Random mix of operations, pairs, wait states and stray start pulses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 5)), 16'($urandom));
            o = 1'($urandom);
            r = 3'($urandom);
            if (!legal_rp(r) && $urandom_range(0, 3) != 0) r = 3'd2;
            w0 = $urandom_range(0, 3);
            w1 = $urandom_range(0, 3);
            run_op(o, r, w0, w1, 1'($urandom), lat, nb, nw, nwf);
            if (legal_rp(r)) chk("rand_latency", lat, 9 + w0 + w1);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
